// File: rtl/pattern_scan_ctrl.sv
// Scan controller: serialises a word MSB-first through a "1011" Mealy detector.
// Build option OVERLAP_EN: a trailing '1' of a match may seed the next match.
module pattern_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [POS_W-1:0] first_pos,
    output logic             hit
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] DET_S0 = 2'd0;
    localparam logic [1:0] DET_S1 = 2'd1;
    localparam logic [1:0] DET_S2 = 2'd2;
    localparam logic [1:0] DET_S3 = 2'd3;

    localparam logic [POS_W-1:0] K_LAST  = POS_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       det_q, det_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [POS_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [POS_W-1:0] first_q, first_d;

    logic       bit_in;
    logic       match;
    logic [1:0] det_next;

    assign bit_in = sreg_q[WIDTH-1];
    assign match  = (det_q == DET_S3) && bit_in;

    always_comb begin
        det_next = DET_S0;
        case (det_q)
            DET_S0: det_next = bit_in ? DET_S1 : DET_S0;
            DET_S1: det_next = bit_in ? DET_S1 : DET_S2;
            DET_S2: det_next = bit_in ? DET_S3 : DET_S0;
`ifdef OVERLAP_EN
            DET_S3: det_next = bit_in ? DET_S1 : DET_S2;
`else
            DET_S3: det_next = bit_in ? DET_S0 : DET_S2;
`endif
            default: det_next = DET_S0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        sreg_d  = sreg_q;
        k_d     = k_q;
        count_d = count_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sreg_d  = data_in;
                    k_d     = '0;
                    count_d = '0;
                    first_d = '0;
                    det_d   = DET_S0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    det_d   = DET_S0;
                    k_d     = '0;
                    count_d = '0;
                    first_d = '0;
                end else begin
                    det_d  = det_next;
                    sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
                    k_d    = k_q + 1'b1;
                    if (match) begin
                        if (count_q != CNT_MAX) begin
                            count_d = count_q + 1'b1;
                        end
                        // count_q==0 means this is the scan's first match
                        if (count_q == '0) begin
                            first_d = k_q;
                        end
                    end
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            det_q   <= DET_S0;
            sreg_q  <= '0;
            k_q     <= '0;
            count_q <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            det_q   <= det_d;
            sreg_q  <= sreg_d;
            k_q     <= k_d;
            count_q <= count_d;
            first_q <= first_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_SHIFT);
    assign done        = (state_q == ST_DONE);
    assign match_count = count_q;
    assign first_pos   = first_q;
    assign hit         = (count_q != '0);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: directed cases plus random words
// against a substring-search reference model.
module tb_pattern_scan_ctrl;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam int POS_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] match_count;
    logic [POS_W-1:0] first_pos;
    logic             hit;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pattern_scan_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W),
        .POS_W(POS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .abort      (abort),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .match_count(match_count),
        .first_pos  (first_pos),
        .hit        (hit)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Occurrences of "1011" reading bit WIDTH-1 first; non-overlapping
    // search restarts after the end of each match.
    task automatic ref_scan(input logic [WIDTH-1:0] w, output int cnt,
                            output int fp);
        int last;
        logic [3:0] win;
        cnt  = 0;
        fp   = 0;
        last = -4;
        for (int k = 3; k < WIDTH; k++) begin
            win = {w[WIDTH-1-(k-3)], w[WIDTH-1-(k-2)],
                   w[WIDTH-1-(k-1)], w[WIDTH-1-k]};
`ifdef OVERLAP_EN
            if (win == 4'b1011) begin
`else
            if (win == 4'b1011 && (k - 3) > last) begin
`endif
                if (cnt == 0) fp = k;
                if (cnt < (1 << CNT_W) - 1) cnt++;
                last = k;
            end
        end
    endtask

    task automatic accept(input logic [WIDTH-1:0] w);
        @(negedge clk);
        chk("ready_before_start", ready, 1);
        start   = 1'b1;
        data_in = w;
        @(negedge clk);
        start   = 1'b0;
        data_in = WIDTH'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic scan(input string tag, input logic [WIDTH-1:0] w);
        int n, cnt, fp;
        ref_scan(w, cnt, fp);
        accept(w);
        chk({tag, "_busy"}, busy, 1);
        wait_done(n);
        chk({tag, "_latency"}, n, WIDTH);
        chk({tag, "_count"}, match_count, cnt);
        chk({tag, "_first"}, first_pos, fp);
        chk({tag, "_hit"}, hit, cnt != 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_ready_after"}, ready, 1);
        chk({tag, "_count_hold"}, match_count, cnt);
    endtask

    initial begin
        int n, dones, t0, t1, cnt, fp;
        logic [WIDTH-1:0] w;
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", match_count, 0);
        chk("rst_first", first_pos, 0);
        chk("rst_hit", hit, 0);
        rst = 1'b0;

        scan("b000", 16'hB000);
`ifdef OVERLAP_EN
        chk("b600_exp", match_count, 1);
        scan("b600", 16'hB600);
        chk("b600_count_const", match_count, 2);
`else
        scan("b600", 16'hB600);
        chk("b600_count_const", match_count, 1);
`endif
        scan("bbbb", 16'hBBBB);
        chk("bbbb_count_const", match_count, 4);
        chk("bbbb_first_const", first_pos, 3);
        scan("ffff", 16'hFFFF);
        chk("ffff_hit_const", hit, 0);
        scan("last_bit", 16'h000B);
        chk("last_bit_first", first_pos, WIDTH - 1);

        // reset in the middle of a scan
        accept(16'hB000);
        repeat (7) @(negedge clk);
        chk("mid_count_before_rst", match_count, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", match_count, 0);
        chk("mid_rst_hit", hit, 0);
        chk("mid_rst_first", first_pos, 0);
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("mid_rst_no_done", dones, 0);
        chk("mid_rst_ready_after", ready, 1);

        // abort at k=5
        accept(16'hB000);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_count", match_count, 0);
        chk("abort_hit", hit, 0);
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", dones, 0);
        scan("rescan", 16'hB000);

        // abort while idle leaves results alone
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_count", match_count, 1);
        chk("idle_abort_ready", ready, 1);

        // start and abort together in idle: start wins
        @(negedge clk);
        start   = 1'b1;
        abort   = 1'b1;
        data_in = 16'hBBBB;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_wins_busy", busy, 1);
        wait_done(n);
        chk("start_wins_latency", n, WIDTH);
        chk("start_wins_count", match_count, 4);
        @(negedge clk);

        // start held high: back-to-back scans
        start   = 1'b1;
        data_in = 16'hBBBB;
        dones   = 0;
        t0      = 0;
        t1      = 0;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) t0 = i;
                if (dones == 2) t1 = i;
                chk("b2b_count", match_count, 4);
            end
        end
        start = 1'b0;
        chk("b2b_dones", dones, 2);
        chk("b2b_period", t1 - t0, WIDTH + 2);
        chk("b2b_first_done", t0, WIDTH + 1);
        @(negedge clk);
        chk("b2b_idle_after", ready, 1);

        // random words
        for (int r = 0; r < 30; r++) begin
            w = WIDTH'($urandom);
            if (r % 3 == 0) w = {4'hB, WIDTH'($urandom) >> 4} ^ WIDTH'($urandom_range(0, 255));
            ref_scan(w, cnt, fp);
            scan("rand", w);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
